// File: rtl/calc_pkg.sv
// Shared op codes, FSM encodings and width default for the X engine.
package calc_pkg;

    localparam int W_DEFAULT = 6;

    localparam logic [2:0] OP_LOAD_SW = 3'd0;
    localparam logic [2:0] OP_ADD     = 3'd1;
    localparam logic [2:0] OP_SUB     = 3'd2;
    localparam logic [2:0] OP_AND     = 3'd3;
    localparam logic [2:0] OP_OR      = 3'd4;
    localparam logic [2:0] OP_XOR     = 3'd5;
    localparam logic [2:0] OP_SHL     = 3'd6;
    localparam logic [2:0] OP_MUL     = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2
    } state_t;

endpackage

// File: rtl/calc_x_engine_if.sv
// Button/operand/result bundle between the panel side and the X engine.
interface calc_x_engine_if
    import calc_pkg::*;
#(
    parameter int W = W_DEFAULT
);
    logic         btn_exec;
    logic         btn_enter;
    logic [2:0]   op;
    logic [W-1:0] sw_val;
    logic [W-1:0] y_in;
    logic [W-1:0] x_out;
    logic         load_y;
    logic         busy;
    logic         ovf;

    modport master (
        output btn_exec, btn_enter, op, sw_val, y_in,
        input  x_out, load_y, busy, ovf
    );

    modport slave (
        input  btn_exec, btn_enter, op, sw_val, y_in,
        output x_out, load_y, busy, ovf
    );
endinterface

// File: rtl/calc_x_engine_btn_edge_sync.sv
// Two-flop synchroniser plus registered rising-edge pulse for a raw button.
module btn_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);
    logic s1, s2, s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            s3    <= s2;
            pulse <= s2 & ~s3;
        end
    end
endmodule

// File: rtl/calc_x_engine.sv
// X accumulator engine: ALU ops on (X,Y), shift-add multiply, load_y issue.
// Optional saturation of overflowing results via `define CALC_SAT_EN.
module calc_x_engine
    import calc_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    calc_x_engine_if.slave  bus
);
    localparam int CW = $clog2(W);

    logic exec_p, enter_p;

    btn_edge_sync u_exec (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.btn_exec),
        .pulse (exec_p)
    );

    btn_edge_sync u_enter (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.btn_enter),
        .pulse (enter_p)
    );

    state_t         state;
    logic [2:0]     op_q;
    logic [W-1:0]   a_q, b_q, sw_q;
    logic [W-1:0]   x_q;
    logic           load_q, ovf_q;
    logic [2*W-1:0] mcand, acc;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;

    logic [W:0]     sum, dif;
    logic [W-1:0]   alu_res;
    logic           alu_ovf;
    logic [2*W-1:0] acc_nxt;
    logic           mul_ovf;
    logic [W-1:0]   mul_res;

    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        dif     = {1'b0, a_q} - {1'b0, b_q};
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (op_q)
            OP_LOAD_SW: alu_res = sw_q;
            OP_ADD: begin
                alu_res = sum[W-1:0];
                alu_ovf = sum[W];
`ifdef CALC_SAT_EN
                if (sum[W]) alu_res = '1;
`endif
            end
            OP_SUB: begin
                alu_res = dif[W-1:0];
                alu_ovf = dif[W];
`ifdef CALC_SAT_EN
                if (dif[W]) alu_res = '0;
`endif
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SHL: begin
                alu_res = {a_q[W-2:0], 1'b0};
                alu_ovf = a_q[W-1];
`ifdef CALC_SAT_EN
                if (a_q[W-1]) alu_res = '1;
`endif
            end
            OP_MUL: alu_res = '0;
        endcase
    end

    // One partial product per MUL cycle; the last cycle's sum is the product.
    always_comb begin
        acc_nxt = acc + (mplier[0] ? mcand : '0);
        mul_ovf = |acc_nxt[2*W-1:W];
        mul_res = acc_nxt[W-1:0];
`ifdef CALC_SAT_EN
        if (mul_ovf) mul_res = '1;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            op_q   <= OP_LOAD_SW;
            a_q    <= '0;
            b_q    <= '0;
            sw_q   <= '0;
            x_q    <= '0;
            load_q <= 1'b0;
            ovf_q  <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            load_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (exec_p) begin
                        op_q   <= bus.op;
                        a_q    <= x_q;
                        b_q    <= bus.y_in;
                        sw_q   <= bus.sw_val;
                        mcand  <= {{W{1'b0}}, x_q};
                        mplier <= bus.y_in;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= (bus.op == OP_MUL) ? ST_MUL : ST_EXEC;
                    end else if (enter_p) begin
                        load_q <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    x_q   <= alu_res;
                    ovf_q <= alu_ovf;
                    state <= ST_IDLE;
                end
                ST_MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        x_q   <= mul_res;
                        ovf_q <= mul_ovf;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.x_out  = x_q;
    assign bus.load_y = load_q;
    assign bus.ovf    = ovf_q;
    assign bus.busy   = (state != ST_IDLE);
endmodule

// File: tb/tb_calc_x_engine.sv
// Directed self-checking bench for calc_x_engine (W=6), with a Y register model.
`timescale 1ns/1ps
module tb_calc_x_engine;
    localparam int W = 6;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   ly_cnt = 0;
    logic [W-1:0] y_model = '0;

    calc_x_engine_if #(.W(W)) bus ();

    calc_x_engine #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.y_in = y_model;

    always @(posedge clk) begin
        if (bus.load_y) begin
            ly_cnt  <= ly_cnt + 1;
            y_model <= bus.x_out;
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] s,
                          input bit with_enter, input bit enter_mid,
                          output int bc);
        int k;
        @(negedge clk);
        bus.op       = o;
        bus.sw_val   = s;
        bus.btn_exec = 1'b1;
        if (with_enter) bus.btn_enter = 1'b1;
        bc = 0;
        k  = 0;
        while (!bus.busy && k < 10) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!bus.busy) begin
            errors++;
            $display("FAIL op_start: busy=%b required 1 (op %0d)", bus.busy, o);
        end
        while (bus.busy && k < 40) begin
            bc++;
            if (enter_mid && bc == 1) bus.btn_enter = 1'b1;
            @(negedge clk);
            k++;
        end
        bus.btn_exec  = 1'b0;
        bus.btn_enter = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic press_enter();
        @(negedge clk);
        bus.btn_enter = 1'b1;
        repeat (10) @(negedge clk);
        bus.btn_enter = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic load_x(input logic [W-1:0] v);
        int bc;
        run_op(3'd0, v, 1'b0, 1'b0, bc);
    endtask

    task automatic set_y(input logic [W-1:0] v);
        load_x(v);
        press_enter();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.x_out, bus.load_y, bus.busy, bus.ovf} !== {6'd0, 3'b000}) begin
            errors++;
            $display("FAIL reset: x=%0d ld=%b busy=%b ovf=%b required 0/0/0/0",
                     bus.x_out, bus.load_y, bus.busy, bus.ovf);
        end
    endtask

    task automatic test_load_enter();
        int c0;
        load_x(6'd42);
        checks++;
        if (bus.x_out !== 6'd42 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL load_sw: x=%0d ovf=%b required 42/0", bus.x_out, bus.ovf);
        end
        c0 = ly_cnt;
        press_enter();
        checks++;
        if (ly_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL enter_pulses: got %0d required 1", ly_cnt - c0);
        end
        checks++;
        if (y_model !== 6'd42 || bus.x_out !== 6'd42) begin
            errors++;
            $display("FAIL enter_y: y=%0d x=%0d required 42/42", y_model, bus.x_out);
        end
    endtask

    task automatic test_add();
        int bc;
        set_y(6'd30);
        load_x(6'd40);
        run_op(3'd1, 6'd0, 1'b0, 1'b0, bc);
        checks++;
`ifdef CALC_SAT_EN
        if (bus.x_out !== 6'd63 || bus.ovf !== 1'b1) begin
            errors++;
            $display("FAIL add: x=%0d ovf=%b required 63/1", bus.x_out, bus.ovf);
        end
`else
        if (bus.x_out !== 6'd6 || bus.ovf !== 1'b1) begin
            errors++;
            $display("FAIL add: x=%0d ovf=%b required 6/1", bus.x_out, bus.ovf);
        end
`endif
        checks++;
        if (bc !== 1) begin
            errors++;
            $display("FAIL exec_busy: %0d cycles required 1", bc);
        end
    endtask

    task automatic test_sub_and();
        int bc;
        logic [W-1:0] exp_sub;
        logic [W-1:0] exp_and;
`ifdef CALC_SAT_EN
        exp_sub = 6'd0;
        exp_and = 6'd0;
`else
        exp_sub = 6'd60;
        exp_and = 6'd8;
`endif
        set_y(6'd9);
        load_x(6'd5);
        run_op(3'd2, 6'd0, 1'b0, 1'b0, bc);
        checks++;
        if (bus.x_out !== exp_sub || bus.ovf !== 1'b1) begin
            errors++;
            $display("FAIL sub: x=%0d ovf=%b required %0d/1", bus.x_out, bus.ovf, exp_sub);
        end
        run_op(3'd3, 6'd0, 1'b0, 1'b0, bc);
        checks++;
        if (bus.x_out !== exp_and || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL and: x=%0d ovf=%b required %0d/0", bus.x_out, bus.ovf, exp_and);
        end
    endtask

    task automatic test_mul();
        int bc;
        logic [W-1:0] exp2;
`ifdef CALC_SAT_EN
        exp2 = 6'd63;
`else
        exp2 = 6'd8;
`endif
        set_y(6'd9);
        load_x(6'd7);
        run_op(3'd7, 6'd0, 1'b0, 1'b0, bc);
        checks++;
        if (bus.x_out !== 6'd63 || bus.ovf !== 1'b0 || bc !== 6) begin
            errors++;
            $display("FAIL mul_7x9: x=%0d ovf=%b busy=%0d required 63/0/6",
                     bus.x_out, bus.ovf, bc);
        end
        set_y(6'd8);
        load_x(6'd9);
        run_op(3'd7, 6'd0, 1'b0, 1'b0, bc);
        checks++;
        if (bus.x_out !== exp2 || bus.ovf !== 1'b1) begin
            errors++;
            $display("FAIL mul_9x8: x=%0d ovf=%b required %0d/1", bus.x_out, bus.ovf, exp2);
        end
    endtask

    task automatic test_busy_ignore();
        int bc, c0;
        load_x(6'd3);
        c0 = ly_cnt;
        run_op(3'd7, 6'd0, 1'b0, 1'b1, bc);
        checks++;
        if (bus.x_out !== 6'd24 || bus.ovf !== 1'b0 || ly_cnt !== c0) begin
            errors++;
            $display("FAIL busy_ignore: x=%0d ovf=%b loads=%0d required 24/0/0",
                     bus.x_out, bus.ovf, ly_cnt - c0);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_requeue: busy=%b required 0", bus.busy);
        end
    endtask

    task automatic test_simultaneous();
        int bc, c0;
        c0 = ly_cnt;
        run_op(3'd5, 6'd0, 1'b1, 1'b0, bc);
        checks++;
        if (bus.x_out !== 6'd16 || ly_cnt !== c0) begin
            errors++;
            $display("FAIL exec_enter: x=%0d loads=%0d required 16/0", bus.x_out, ly_cnt - c0);
        end
    endtask

    task automatic test_shl();
        int bc;
        logic [W-1:0] exp2;
`ifdef CALC_SAT_EN
        exp2 = 6'd63;
`else
        exp2 = 6'd0;
`endif
        run_op(3'd6, 6'd0, 1'b0, 1'b0, bc);
        checks++;
        if (bus.x_out !== 6'd32 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL shl_1: x=%0d ovf=%b required 32/0", bus.x_out, bus.ovf);
        end
        run_op(3'd6, 6'd0, 1'b0, 1'b0, bc);
        checks++;
        if (bus.x_out !== exp2 || bus.ovf !== 1'b1) begin
            errors++;
            $display("FAIL shl_2: x=%0d ovf=%b required %0d/1", bus.x_out, bus.ovf, exp2);
        end
    endtask

    task automatic test_reset_mid_mul();
        int k, bc, c0;
        load_x(6'd5);
        c0 = ly_cnt;
        @(negedge clk);
        bus.op       = 3'd7;
        bus.btn_exec = 1'b1;
        k  = 0;
        bc = 0;
        while (bc < 3 && k < 30) begin
            @(negedge clk);
            if (bus.busy) bc++;
            k++;
        end
        checks++;
        if (bc !== 3) begin
            errors++;
            $display("FAIL mid_mul_start: busy cycles=%0d required 3", bc);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.x_out, bus.load_y, bus.busy, bus.ovf} !== {6'd0, 3'b000}) begin
            errors++;
            $display("FAIL async_reset: x=%0d ld=%b busy=%b ovf=%b required 0/0/0/0",
                     bus.x_out, bus.load_y, bus.busy, bus.ovf);
        end
        @(negedge clk);
        bus.btn_exec = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.x_out !== 6'd0 || bus.busy !== 1'b0 || ly_cnt !== c0) begin
            errors++;
            $display("FAIL post_abort: x=%0d busy=%b loads=%0d required 0/0/0",
                     bus.x_out, bus.busy, ly_cnt - c0);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.btn_exec  = 1'b0;
        bus.btn_enter = 1'b0;
        bus.op        = 3'd0;
        bus.sw_val    = '0;
        test_reset();
        test_load_enter();
        test_add();
        test_sub_and();
        test_mul();
        test_busy_ignore();
        test_simultaneous();
        test_shl();
        test_reset_mid_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
